// File: rtl/if_prefetch_unit_if.sv
// Wishbone classic bus between the instruction prefetch unit (master) and the
// instruction memory or bus fabric (slave).
interface if_prefetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_ack_i;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic                    wb_we_o;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// IF-stage prefetcher: Wishbone classic read master filling a {pc, instr} FIFO,
// flushed by branch redirects. Define IF_PREFETCH_PERF_EN for fetch/flush counters.
module if_prefetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
`ifdef IF_PREFETCH_PERF_EN
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_flush_cnt_o,
`endif
    if_prefetch_unit_if.master    wb
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic                  empty, push, pop;
    logic                  redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    assign empty         = (count_reg == '0);
    assign instr_valid_o = !empty && !redirect_i;
    assign pop           = instr_valid_o && !stall_i;
    assign push          = (state_reg == ST_REQ) && wb.wb_ack_i && !redirect_i;
    assign count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);

    assign instr_o = instr_mem[rd_ptr_reg];
    assign pc_o    = pc_mem[rd_ptr_reg];

    assign wb.wb_cyc_o = (state_reg != ST_IDLE);
    assign wb.wb_stb_o = (state_reg != ST_IDLE);
    assign wb.wb_adr_o = adr_reg;
    assign wb.wb_dat_o = '0;
    assign wb.wb_sel_o = '1;
    assign wb.wb_we_o  = 1'b0;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        adr_next      = adr_reg;
        if (redirect_i) begin
            fetch_pc_next = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            // An open bus cycle must still finish; an ack landing now ends it.
            case (state_reg)
                ST_REQ, ST_DRAIN: state_next = wb.wb_ack_i ? ST_IDLE : ST_DRAIN;
                default:          state_next = ST_IDLE;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (count_reg < DEPTH_CNT) begin
                        state_next = ST_REQ;
                        adr_next   = fetch_pc_reg;
                    end
                end
                ST_REQ: begin
                    if (wb.wb_ack_i) begin
                        fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);
                        if (count_next < DEPTH_CNT) begin
                            adr_next = fetch_pc_reg + ADDR_WIDTH'(4);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wb.wb_ack_i) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= PC_ADDR;
            adr_reg      <= PC_ADDR;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            adr_reg      <= adr_next;
            if (redirect_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
                count_reg  <= count_next;
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
            instr_mem[wr_ptr_reg] <= wb.wb_dat_i;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetch_reg, perf_flush_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            perf_fetch_reg <= perf_fetch_reg + 32'(push);
            perf_flush_reg <= perf_flush_reg + 32'(redirect_i);
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_reg;
    assign perf_flush_cnt_o = perf_flush_reg;
`endif
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: table-driven streaming/stall vectors plus
// hand-written redirect, drain and reset-mid-cycle sequences.
module tb_if_prefetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    if_prefetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    if_prefetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .PC_ADDR   (32'h8000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .stall_i      (stall),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .pc_o         (pc),
`ifdef IF_PREFETCH_PERF_EN
        .perf_fetch_cnt_o(perf_fetch),
        .perf_flush_cnt_o(perf_flush),
`endif
        .wb           (bus)
    );

    int checks = 0;
    int errors = 0;
    bit slave_en;
    int lat;
    int wcnt;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    // Slave: acks after `lat` wait cycles, data derived from the address.
    always @(negedge clk) begin
        if (slave_en) begin
            if (bus.wb_cyc_o && bus.wb_stb_o) begin
                if (bus.wb_ack_i) wcnt = 0;
                bus.wb_ack_i = (wcnt >= lat);
                bus.wb_dat_i = word(bus.wb_adr_o);
                wcnt++;
            end else begin
                bus.wb_ack_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Ends in the drive phase of the first cycle after reset deassertion.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1; redirect = 1'b0; stall = 1'b0; slave_en = 1'b1; lat = 0;
        next_cycle();
        sample();
        check("rst_cyc", {31'b0, bus.wb_cyc_o}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_adr", bus.wb_adr_o, 32'h8000_0000);
        next_cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          first;
        bit          stall;
        bit          valid;
        logic [31:0] pc;
        bit          cyc;
        logic [31:0] adr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        slave_en = 1'b1; lat = 0; wcnt = 0;
        bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0;

        // Streaming, no stall
        vecs[0]  = '{1, 0, 0, 32'h0,         0, 32'h0};
        vecs[1]  = '{0, 0, 0, 32'h0,         1, 32'h8000_0000};
        vecs[2]  = '{0, 0, 1, 32'h8000_0000, 1, 32'h8000_0004};
        vecs[3]  = '{0, 0, 1, 32'h8000_0004, 1, 32'h8000_0008};
        vecs[4]  = '{0, 0, 1, 32'h8000_0008, 1, 32'h8000_000C};
        vecs[5]  = '{0, 0, 1, 32'h8000_000C, 1, 32'h8000_0010};
        // Stall until full, then release
        vecs[6]  = '{1, 1, 0, 32'h0,         0, 32'h0};
        vecs[7]  = '{0, 1, 0, 32'h0,         1, 32'h8000_0000};
        vecs[8]  = '{0, 1, 1, 32'h8000_0000, 1, 32'h8000_0004};
        vecs[9]  = '{0, 1, 1, 32'h8000_0000, 1, 32'h8000_0008};
        vecs[10] = '{0, 1, 1, 32'h8000_0000, 1, 32'h8000_000C};
        vecs[11] = '{0, 1, 1, 32'h8000_0000, 0, 32'h0};
        vecs[12] = '{0, 0, 1, 32'h8000_0000, 0, 32'h0};
        vecs[13] = '{0, 0, 1, 32'h8000_0004, 0, 32'h0};
        vecs[14] = '{0, 0, 1, 32'h8000_0008, 1, 32'h8000_0010};
        vecs[15] = '{0, 0, 1, 32'h8000_000C, 1, 32'h8000_0014};
        vecs[16] = '{0, 0, 1, 32'h8000_0010, 1, 32'h8000_0018};

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].first) do_reset();
            else next_cycle();
            stall = vecs[i].stall;
            sample();
            $display("vec %0d: stall=%0b valid=%0b pc=%h cyc=%0b adr=%h",
                     i, stall, instr_valid, pc, bus.wb_cyc_o, bus.wb_adr_o);
            check("vec_valid", {31'b0, instr_valid}, {31'b0, vecs[i].valid});
            check("vec_cyc", {31'b0, bus.wb_cyc_o}, {31'b0, vecs[i].cyc});
            check("vec_stb", {31'b0, bus.wb_stb_o}, {31'b0, vecs[i].cyc});
            if (vecs[i].valid) begin
                check("vec_pc", pc, vecs[i].pc);
                check("vec_instr", instr, word(vecs[i].pc));
            end
            if (vecs[i].cyc) check("vec_adr", bus.wb_adr_o, vecs[i].adr);
        end

        // Redirect during a slow bus cycle: stale cycle drained, data discarded
        do_reset();
        lat = 2;
        sample();
        next_cycle(); sample();
        check("drn_adr0", bus.wb_adr_o, 32'h8000_0000);
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        sample();
        check("drn_cyc_wait", {31'b0, bus.wb_cyc_o}, 32'd1);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("drn_stale_adr", bus.wb_adr_o, 32'h8000_0000);
        check("drn_stale_cyc", {31'b0, bus.wb_cyc_o}, 32'd1);
        check("drn_empty", {31'b0, instr_valid}, 32'd0);
        next_cycle(); sample();
        check("drn_idle", {31'b0, bus.wb_cyc_o}, 32'd0);
        check("drn_empty2", {31'b0, instr_valid}, 32'd0);
        next_cycle(); sample();
        check("drn_new_adr", bus.wb_adr_o, 32'h8000_0100);
        check("drn_new_cyc", {31'b0, bus.wb_cyc_o}, 32'd1);
        next_cycle(); next_cycle(); sample();
        check("drn_empty3", {31'b0, instr_valid}, 32'd0);
        next_cycle(); sample();
        $display("drain: valid=%0b pc=%h instr=%h", instr_valid, pc, instr);
        check("drn_valid", {31'b0, instr_valid}, 32'd1);
        check("drn_pc", pc, 32'h8000_0100);
        check("drn_instr", instr, word(32'h8000_0100));

        // Redirect coinciding with an ack: word dropped, address aligned
        do_reset();
        sample();
        next_cycle(); sample();
        check("rda_adr0", bus.wb_adr_o, 32'h8000_0000);
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h8000_0203;
        sample();
        check("rda_valid_redir", {31'b0, instr_valid}, 32'd0);
        check("rda_ack", {31'b0, bus.wb_ack_i}, 32'd1);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("rda_idle", {31'b0, bus.wb_cyc_o}, 32'd0);
        check("rda_flushed", {31'b0, instr_valid}, 32'd0);
        next_cycle(); sample();
        check("rda_new_adr", bus.wb_adr_o, 32'h8000_0200);
        next_cycle(); sample();
        $display("redir+ack: valid=%0b pc=%h instr=%h", instr_valid, pc, instr);
        check("rda_valid", {31'b0, instr_valid}, 32'd1);
        check("rda_pc", pc, 32'h8000_0200);
        check("rda_instr", instr, word(32'h8000_0200));

        // Reset mid-REQ; a late ack while idle must be ignored
        do_reset();
        lat = 2;
        sample();
        next_cycle(); sample();
        check("rmr_cyc", {31'b0, bus.wb_cyc_o}, 32'd1);
        next_cycle();
        reset = 1'b1; slave_en = 1'b0; bus.wb_ack_i = 1'b0;
        sample();
        next_cycle();
        reset = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF;
        sample();
        check("rmr_idle", {31'b0, bus.wb_cyc_o}, 32'd0);
        check("rmr_valid0", {31'b0, instr_valid}, 32'd0);
        next_cycle();
        bus.wb_ack_i = 1'b0; wcnt = 0; lat = 0; slave_en = 1'b1;
        sample();
        check("rmr_refetch_adr", bus.wb_adr_o, 32'h8000_0000);
        check("rmr_refetch_cyc", {31'b0, bus.wb_cyc_o}, 32'd1);
        check("rmr_no_push", {31'b0, instr_valid}, 32'd0);
        next_cycle(); sample();
        $display("reset-mid-req: valid=%0b pc=%h instr=%h", instr_valid, pc, instr);
        check("rmr_valid", {31'b0, instr_valid}, 32'd1);
        check("rmr_pc", pc, 32'h8000_0000);
        check("rmr_instr", instr, word(32'h8000_0000));

`ifdef IF_PREFETCH_PERF_EN
        do_reset();
        repeat (11) next_cycle();
        redirect = 1'b1; redirect_pc = 32'h8000_0000;
        next_cycle();
        next_cycle();
        redirect = 1'b0;
        sample();
        $display("perf: fetch=%0d flush=%0d", perf_fetch, perf_flush);
        check("perf_fetch", perf_fetch, 32'd10);
        check("perf_flush", perf_flush, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
